// File: rtl/cpu7_backend.sv
// cpu7_backend: EX/MEM/WB back end of a 3-stage RISC-style pipeline with forwarding, load-use and memory-wait stalls.
// Ports: i_clk/i_reset (async, active-high); EX-slot decode inputs i_*_e; o_stall/o_redirect/o_pcnext_e
// back to the front end; o_dmem_* request from MEM with i_dmem_rdata/i_dmem_ready completing it.
module cpu7_backend #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  localparam int RFIDX = $clog2(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid_e,
  input  logic [XLEN-1:0]  i_pc_e,
  input  logic [RFIDX-1:0] i_rs1idx_e,
  input  logic [RFIDX-1:0] i_rs2idx_e,
  input  logic [RFIDX-1:0] i_rdidx_e,
  input  logic [XLEN-1:0]  i_imm_e,
  input  logic [3:0]       i_alucontrol_e,
  input  logic             i_alusrc_e,
  input  logic [2:0]       i_branchtype_e,
  input  logic             i_memwrite_e,
  input  logic             i_memtoreg_e,
  input  logic             i_regwrite_e,
  input  logic             i_jump_e,
  output logic             o_stall,
  output logic             o_redirect,
  output logic [XLEN-1:0]  o_pcnext_e,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [XLEN-1:0]  o_dmem_addr,
  output logic [XLEN-1:0]  o_dmem_wdata,
  input  logic [XLEN-1:0]  i_dmem_rdata,
  input  logic             i_dmem_ready
);
  localparam int SH = $clog2(XLEN);
  logic [XLEN-1:0] r_rf [NREGS];
  logic r_mem_valid, r_mem_load, r_mem_store, r_mem_rw;
  logic [RFIDX-1:0] r_mem_rd;
  logic [XLEN-1:0] r_mem_alu, r_mem_res, r_mem_wd;
  logic r_wb_valid, r_wb_rw;
  logic [RFIDX-1:0] r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic [XLEN-1:0] w_a, w_rs2, w_b, w_alu, w_pc4;
  logic [SH-1:0] w_sh;
  logic w_taken, w_wait, w_lu;
  // Loads in MEM have no data yet, so they are never a forwarding source; WB also covers same-cycle write/read.
  function automatic logic [XLEN-1:0] fwd(input logic [RFIDX-1:0] idx);
    return (idx == '0) ? '0 :
           (r_mem_valid && r_mem_rw && !r_mem_load && r_mem_rd == idx) ? r_mem_res :
           (r_wb_valid && r_wb_rw && r_wb_rd == idx) ? r_wb_data : r_rf[idx];
  endfunction
  assign w_a = fwd(i_rs1idx_e);
  assign w_rs2 = fwd(i_rs2idx_e);
  assign w_b = i_alusrc_e ? i_imm_e : w_rs2;
  assign w_sh = w_b[SH-1:0];
  assign w_pc4 = i_pc_e + XLEN'(4);
  always_comb begin
    case (i_alucontrol_e)
      4'd1: w_alu = w_a - w_b;
      4'd2: w_alu = w_a & w_b;
      4'd3: w_alu = w_a | w_b;
      4'd4: w_alu = w_a ^ w_b;
      4'd5: w_alu = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
      4'd6: w_alu = {{(XLEN-1){1'b0}}, w_a < w_b};
      4'd7: w_alu = w_a << w_sh;
      4'd8: w_alu = w_a >> w_sh;
      4'd9: w_alu = XLEN'($signed(w_a) >>> w_sh);
      default: w_alu = w_a + w_b;
    endcase
  end
  always_comb begin
    case (i_branchtype_e)
      3'd1: w_taken = w_a == w_rs2;
      3'd2: w_taken = w_a != w_rs2;
      3'd3: w_taken = $signed(w_a) < $signed(w_rs2);
      3'd4: w_taken = $signed(w_a) >= $signed(w_rs2);
      3'd5: w_taken = w_a < w_rs2;
      3'd6: w_taken = w_a >= w_rs2;
      default: w_taken = 1'b0;
    endcase
  end
  assign w_wait = r_mem_valid & (r_mem_load | r_mem_store) & ~i_dmem_ready;
  assign w_lu = i_valid_e & r_mem_valid & r_mem_load & (r_mem_rd != '0) &
                ((r_mem_rd == i_rs1idx_e) | (r_mem_rd == i_rs2idx_e));
  assign o_stall = ~i_reset & (w_wait | w_lu);
  assign o_redirect = ~i_reset & i_valid_e & ~o_stall & (i_jump_e | w_taken);
  assign o_pcnext_e = !o_redirect ? w_pc4 : i_jump_e ? ((w_a + i_imm_e) & ~XLEN'(1)) : i_pc_e + i_imm_e;
  assign o_dmem_req = r_mem_valid & (r_mem_load | r_mem_store);
  assign o_dmem_we = r_mem_valid & r_mem_store;
  assign o_dmem_addr = r_mem_alu;
  assign o_dmem_wdata = r_mem_wd;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
      {r_mem_valid, r_mem_load, r_mem_store, r_mem_rw} <= '0;
      r_mem_rd <= '0;
      r_mem_alu <= '0;
      r_mem_res <= '0;
      r_mem_wd <= '0;
      {r_wb_valid, r_wb_rw} <= '0;
      r_wb_rd <= '0;
      r_wb_data <= '0;
    end else begin
      if (w_wait) begin
        r_wb_valid <= 1'b0;
      end else begin
        r_wb_valid <= r_mem_valid;
        r_wb_rw <= r_mem_rw;
        r_wb_rd <= r_mem_rd;
        r_wb_data <= r_mem_load ? i_dmem_rdata : r_mem_res;
        r_mem_valid <= i_valid_e & ~w_lu;
        r_mem_load <= i_memtoreg_e;
        r_mem_store <= i_memwrite_e;
        r_mem_rw <= i_regwrite_e & ~i_memwrite_e & (i_rdidx_e != '0);
        r_mem_rd <= i_rdidx_e;
        r_mem_alu <= w_alu;
        r_mem_res <= i_jump_e ? w_pc4 : w_alu;
        r_mem_wd <= w_rs2;
      end
      if (r_wb_valid && r_wb_rw) r_rf[r_wb_rd] <= r_wb_data;
    end
  end
endmodule

// File: tb/tb_cpu7_backend.sv
// tb_cpu7_backend: table-driven and directed-sequence self-checking bench for cpu7_backend.
module tb_cpu7_backend;
  logic clk = 0, reset = 1;
  logic valid_e = 0, alusrc_e = 0, memwrite_e = 0, memtoreg_e = 0, regwrite_e = 0, jump_e = 0;
  logic [31:0] pc_e = 0, imm_e = 0, dmem_rdata = 32'h1234;
  logic [4:0] rs1_e = 0, rs2_e = 0, rd_e = 0;
  logic [3:0] alu_e = 0;
  logic [2:0] bt_e = 0;
  logic dmem_ready = 1;
  logic stall, redirect, dmem_req, dmem_we;
  logic [31:0] pcnext, dmem_addr, dmem_wdata;
  int n_pass = 0, n_total = 0;
  cpu7_backend dut (
    .i_clk(clk), .i_reset(reset), .i_valid_e(valid_e), .i_pc_e(pc_e),
    .i_rs1idx_e(rs1_e), .i_rs2idx_e(rs2_e), .i_rdidx_e(rd_e), .i_imm_e(imm_e),
    .i_alucontrol_e(alu_e), .i_alusrc_e(alusrc_e), .i_branchtype_e(bt_e),
    .i_memwrite_e(memwrite_e), .i_memtoreg_e(memtoreg_e), .i_regwrite_e(regwrite_e), .i_jump_e(jump_e),
    .o_stall(stall), .o_redirect(redirect), .o_pcnext_e(pcnext),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
    .i_dmem_rdata(dmem_rdata), .i_dmem_ready(dmem_ready)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic v; logic [31:0] pc; logic [4:0] rs1, rs2, rd; logic [31:0] imm;
    logic [3:0] alu; logic src; logic [2:0] bt; logic mw, mr, rw, j;
    logic chk; logic [31:0] addr; logic redir; logic [31:0] pcn;
  } vec_t;
  vec_t vecs[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask
  task automatic drive(input vec_t x);
    valid_e = x.v; pc_e = x.pc; rs1_e = x.rs1; rs2_e = x.rs2; rd_e = x.rd; imm_e = x.imm;
    alu_e = x.alu; alusrc_e = x.src; bt_e = x.bt; memwrite_e = x.mw; memtoreg_e = x.mr;
    regwrite_e = x.rw; jump_e = x.j;
  endtask
  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
      input logic [31:0] imm, input logic [3:0] alu, input logic src, input logic [2:0] bt,
      input logic mw, mr, rw, j, input logic chk, input logic [31:0] addr, input logic redir,
      input logic [31:0] pcn);
    vec_t x;
    x.v = v; x.pc = pc; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd; x.imm = imm; x.alu = alu; x.src = src;
    x.bt = bt; x.mw = mw; x.mr = mr; x.rw = rw; x.j = j; x.chk = chk; x.addr = addr;
    x.redir = redir; x.pcn = pcn;
    return x;
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    vec_t nop;
    nop = mk(0, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h504);
    //          v  pc      rs1 rs2 rd imm           alu src bt mw mr rw j  chk addr          redir pcnext
    vecs.push_back(mk(1, 32'h000, 0, 0, 1, 32'd5,        0, 1, 0, 0, 0, 1, 0, 0, 0,            0, 32'h004));
    vecs.push_back(mk(1, 32'h004, 1, 1, 2, 0,            0, 0, 0, 0, 0, 1, 0, 1, 32'd5,        0, 32'h008));
    vecs.push_back(mk(1, 32'h008, 0, 0, 5, 32'hffffffff, 0, 1, 0, 0, 0, 1, 0, 1, 32'd10,       0, 32'h00c));
    vecs.push_back(mk(1, 32'h00c, 0, 0, 6, 32'd1,        0, 1, 0, 0, 0, 1, 0, 1, 32'hffffffff, 0, 32'h010));
    vecs.push_back(mk(1, 32'h100, 5, 6, 0, 32'h20,       0, 0, 3, 0, 0, 0, 0, 1, 32'd1,        1, 32'h120));
    vecs.push_back(mk(1, 32'h100, 5, 6, 0, 32'h20,       0, 0, 5, 0, 0, 0, 0, 1, 32'd0,        0, 32'h104));
    vecs.push_back(mk(1, 32'h104, 0, 0, 8, 32'h203,      0, 1, 0, 0, 0, 1, 0, 1, 32'd0,        0, 32'h108));
    vecs.push_back(mk(1, 32'h040, 8, 0, 1, 0,            0, 1, 0, 0, 0, 1, 1, 1, 32'h203,      1, 32'h202));
    vecs.push_back(mk(1, 32'h044, 0, 0, 0, 32'd7,        0, 1, 0, 0, 0, 1, 0, 1, 32'h203,      0, 32'h048));
    vecs.push_back(mk(1, 32'h048, 1, 0, 9, 0,            0, 0, 0, 0, 0, 1, 0, 1, 32'd7,        0, 32'h04c));
    vecs.push_back(mk(1, 32'h04c, 0, 0, 10, 0,           0, 0, 0, 0, 0, 1, 0, 1, 32'h44,       0, 32'h050));
    vecs.push_back(mk(1, 32'h050, 1, 6, 11, 0,           1, 0, 0, 0, 0, 1, 0, 1, 32'd0,        0, 32'h054));
    vecs.push_back(mk(1, 32'h054, 5, 1, 12, 0,           2, 0, 0, 0, 0, 1, 0, 1, 32'h43,       0, 32'h058));
    vecs.push_back(mk(1, 32'h058, 8, 6, 13, 0,           3, 0, 0, 0, 0, 1, 0, 1, 32'h44,       0, 32'h05c));
    vecs.push_back(mk(1, 32'h05c, 1, 8, 14, 0,           4, 0, 0, 0, 0, 1, 0, 1, 32'h203,      0, 32'h060));
    vecs.push_back(mk(1, 32'h060, 5, 6, 15, 0,           5, 0, 0, 0, 0, 1, 0, 1, 32'h247,      0, 32'h064));
    vecs.push_back(mk(1, 32'h064, 5, 6, 16, 0,           6, 0, 0, 0, 0, 1, 0, 1, 32'd1,        0, 32'h068));
    vecs.push_back(mk(1, 32'h068, 6, 0, 17, 32'h23,      7, 1, 0, 0, 0, 1, 0, 1, 32'd0,        0, 32'h06c));
    vecs.push_back(mk(1, 32'h06c, 5, 0, 18, 32'd28,      8, 1, 0, 0, 0, 1, 0, 1, 32'd8,        0, 32'h070));
    vecs.push_back(mk(1, 32'h070, 5, 1, 19, 0,           9, 0, 0, 0, 0, 1, 0, 1, 32'hf,        0, 32'h074));
    vecs.push_back(mk(1, 32'h074, 5, 6, 20, 0,           0, 0, 0, 0, 0, 1, 0, 1, 32'hffffffff, 0, 32'h078));
    vecs.push_back(mk(1, 32'h200, 1, 1, 0, 32'hfffffff8, 0, 0, 1, 0, 0, 0, 0, 1, 32'd0,        1, 32'h1f8));
    vecs.push_back(mk(1, 32'h200, 1, 1, 0, 32'hfffffff8, 0, 0, 2, 0, 0, 0, 0, 1, 32'h88,       0, 32'h204));
    vecs.push_back(mk(1, 32'h300, 5, 6, 0, 32'h10,       0, 0, 4, 0, 0, 0, 0, 1, 32'h88,       0, 32'h304));
    vecs.push_back(mk(1, 32'h300, 5, 6, 0, 32'h10,       0, 0, 6, 0, 0, 0, 0, 1, 32'd0,        1, 32'h310));
    vecs.push_back(mk(1, 32'h400, 6, 0, 21, 32'd4,      12, 1, 7, 0, 0, 1, 0, 1, 32'd0,        0, 32'h404));
    vecs.push_back(mk(0, 32'h500, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 1, 1, 32'd5,        0, 32'h504));
    valid_e = 1; jump_e = 1;
    #2;
    check("rst_stall", {31'b0, stall}, 0);
    check("rst_redirect", {31'b0, redirect}, 0);
    check("rst_req", {30'b0, dmem_req, dmem_we}, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    step();
    step();
    reset = 0;
    foreach (vecs[k]) begin
      drive(vecs[k]);
      @(negedge clk);
      check($sformatf("v%0d_stall", k), {31'b0, stall}, 0);
      check($sformatf("v%0d_redirect", k), {31'b0, redirect}, {31'b0, vecs[k].redir});
      check($sformatf("v%0d_pcnext", k), pcnext, vecs[k].pcn);
      if (vecs[k].chk) check($sformatf("v%0d_addr", k), dmem_addr, vecs[k].addr);
      step();
    end
    // Load-use: LW x3,0x80(x0) then ADD x4,x3,x0
    drive(mk(1, 32'h600, 0, 0, 3, 32'h80, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    step();
    drive(mk(1, 32'h604, 3, 0, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("lu_stall1", {31'b0, stall}, 1);
    check("lu_req", {30'b0, dmem_req, dmem_we}, 32'd2);
    check("lu_addr", dmem_addr, 32'h80);
    step();
    @(negedge clk);
    check("lu_stall2", {31'b0, stall}, 0);
    check("lu_req_bubble", {31'b0, dmem_req}, 0);
    step();
    drive(nop);
    @(negedge clk);
    check("lu_x4", dmem_addr, 32'h1234);
    step();
    // Store wait: SW x1,0x90(x0) with three not-ready cycles, JALR held behind it
    drive(mk(1, 32'h700, 0, 1, 0, 32'h90, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step();
    drive(mk(1, 32'h080, 0, 0, 0, 32'h300, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    dmem_ready = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("sw_stall%0d", c), {31'b0, stall}, 1);
      check($sformatf("sw_req%0d", c), {30'b0, dmem_req, dmem_we}, 32'd3);
      check($sformatf("sw_addr%0d", c), dmem_addr, 32'h90);
      check($sformatf("sw_wdata%0d", c), dmem_wdata, 32'h44);
      check($sformatf("sw_redirect%0d", c), {31'b0, redirect}, 0);
      step();
    end
    dmem_ready = 1;
    @(negedge clk);
    check("sw_release_stall", {31'b0, stall}, 0);
    check("sw_release_redirect", {31'b0, redirect}, 1);
    check("sw_release_pcnext", pcnext, 32'h300);
    step();
    // Reset while a load waits
    drive(mk(1, 32'h800, 0, 0, 22, 32'h40, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    step();
    drive(mk(1, 32'h900, 0, 0, 0, 32'h10, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    dmem_ready = 0;
    @(negedge clk);
    check("ldw_req", {31'b0, dmem_req}, 1);
    check("ldw_stall", {31'b0, stall}, 1);
    #2;
    reset = 1;
    #1;
    check("ldw_rst_stall", {31'b0, stall}, 0);
    check("ldw_rst_redirect", {31'b0, redirect}, 0);
    check("ldw_rst_req", {30'b0, dmem_req, dmem_we}, 0);
    check("ldw_rst_addr", dmem_addr, 0);
    check("ldw_rst_wdata", dmem_wdata, 0);
    step();
    reset = 0;
    dmem_ready = 1;
    drive(mk(1, 32'h904, 1, 0, 20, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    step();
    drive(nop);
    @(negedge clk);
    check("post_rst_x1", dmem_addr, 0);
    check("post_rst_req", {31'b0, dmem_req}, 0);
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
